fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 108 ++++++++++
 tb/tb_fetch_unit.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, dual-port instruction memory addressing
// (current word + lookahead) and the IF/ID pipeline register.
// Optional J predecode is enabled by defining FETCH_PREDECODE_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned ADDR_W   = 6
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] imem_a1,
  output logic [ADDR_W-1:0] imem_a2,
  input  logic [31:0]       imem_rd1,
  input  logic [31:0]       imem_rd2,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              if_valid,
  output logic [31:0]       if_pc,
  output logic [31:0]       if_instr,
  output logic [31:0]       if_instr_next,
  output logic              if_predicted
);

  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_next_q, instr_next_d;
  logic [31:0] next_pc;
  logic        take_jump;

  assign imem_a1 = pc_q[ADDR_W+1:2];
  assign imem_a2 = imem_a1 + ADDR_W'(1);

`ifdef FETCH_PREDECODE_EN
  logic pred_q, pred_d;

  // A J already in the fetch window is followed immediately; decode must not redirect on it.
  assign take_jump = (imem_rd1[31:26] == 6'b000010);
  assign next_pc   = take_jump ? {pc_q[31:28], imem_rd1[25:0], 2'b00} : pc_q + 32'd4;
`else
  assign take_jump = 1'b0;
  assign next_pc   = pc_q + 32'd4;
`endif

  always_comb begin
    // NOTE: every _d gets a hold default first so no path leaves one unassigned (no latch).
    pc_d         = pc_q;
    valid_d      = valid_q;
    if_pc_d      = if_pc_q;
    instr_d      = instr_q;
    instr_next_d = instr_next_q;
`ifdef FETCH_PREDECODE_EN
    pred_d       = pred_q;
`endif
    if (redirect_valid) begin
      // Low address bits dropped by masking so misaligned targets land on a word.
      pc_d    = redirect_pc & 32'hFFFF_FFFC;
      valid_d = 1'b0;
`ifdef FETCH_PREDECODE_EN
      pred_d  = 1'b0;
`endif
    end else if (!stall) begin
      pc_d         = next_pc;
      valid_d      = 1'b1;
      if_pc_d      = pc_q;
      instr_d      = imem_rd1;
      instr_next_d = imem_rd2;
`ifdef FETCH_PREDECODE_EN
      pred_d       = take_jump;
`endif
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so all flops update from pre-edge values.
    if (rst) begin
      pc_q         <= RESET_PC;
      valid_q      <= 1'b0;
      if_pc_q      <= 32'd0;
      instr_q      <= 32'd0;
      instr_next_q <= 32'd0;
`ifdef FETCH_PREDECODE_EN
      pred_q       <= 1'b0;
`endif
    end else begin
      pc_q         <= pc_d;
      valid_q      <= valid_d;
      if_pc_q      <= if_pc_d;
      instr_q      <= instr_d;
      instr_next_q <= instr_next_d;
`ifdef FETCH_PREDECODE_EN
      pred_q       <= pred_d;
`endif
    end
  end

  assign if_valid      = valid_q;
  assign if_pc         = if_pc_q;
  assign if_instr      = instr_q;
  assign if_instr_next = instr_next_q;
`ifdef FETCH_PREDECODE_EN
  assign if_predicted  = pred_q;
`else
  assign if_predicted  = take_jump;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: bench-side fetch model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_fetch_unit;

  localparam int ADDR_W = 6;
  localparam int DEPTH  = 64;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] imem_a1, imem_a2;
  logic [31:0]       imem_rd1, imem_rd2;
  logic              stall, redirect_valid;
  logic [31:0]       redirect_pc;
  logic              if_valid, if_predicted;
  logic [31:0]       if_pc, if_instr, if_instr_next;

  int checks = 0;
  int errors = 0;

  logic [31:0] rom [DEPTH];

  always #5 clk = ~clk;

  assign imem_rd1 = rom[imem_a1];
  assign imem_rd2 = rom[imem_a2];

  fetch_unit #(.RESET_PC(32'h0000_0000), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .imem_a1(imem_a1), .imem_a2(imem_a2),
    .imem_rd1(imem_rd1), .imem_rd2(imem_rd2),
    .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
    .if_instr_next(if_instr_next), .if_predicted(if_predicted)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: byte-address PC, word-indexed ROM lookups modulo depth.
  logic [31:0] m_pc, m_if_pc, m_instr, m_next;
  logic        m_valid, m_pred, m_seen = 1'b0;

  always @(posedge clk) begin
    logic [31:0] w;
    w = rom[(m_pc / 4) % DEPTH];
    if (rst) begin
      m_pc <= 32'h0; m_valid <= 1'b0; m_if_pc <= 32'h0;
      m_instr <= 32'h0; m_next <= 32'h0; m_pred <= 1'b0; m_seen <= 1'b1;
    end else if (redirect_valid) begin
      m_pc    <= (redirect_pc / 4) * 4;
      m_valid <= 1'b0;
      m_pred  <= 1'b0;
    end else if (!stall) begin
      m_valid <= 1'b1;
      m_if_pc <= m_pc;
      m_instr <= w;
      m_next  <= rom[((m_pc / 4) + 1) % DEPTH];
      m_pc    <= m_pc + 32'd4;
      m_pred  <= 1'b0;
`ifdef FETCH_PREDECODE_EN
      if (w[31:26] == 6'd2) begin
        m_pc   <= {m_pc[31:28], w[25:0], 2'b00};
        m_pred <= 1'b1;
      end
`endif
    end
  end

  always @(negedge clk) begin
    if (m_seen) begin
      check("cmp_a1",    32'(imem_a1), (m_pc / 4) % DEPTH);
      check("cmp_a2",    32'(imem_a2), ((m_pc / 4) + 1) % DEPTH);
      check("cmp_valid", 32'(if_valid), 32'(m_valid));
      check("cmp_pred",  32'(if_predicted), 32'(m_pred));
      check("cmp_if_pc", if_pc, m_if_pc);
      check("cmp_instr", if_instr, m_instr);
      check("cmp_next",  if_instr_next, m_next);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct { logic st; logic rv; logic [31:0] tgt; } vec_t;
  vec_t vecs [16];

  initial begin
    for (int i = 0; i < DEPTH; i++) rom[i] = 32'hA000_0000 | 32'(i);
    rom[4] = 32'h0800_0000;   // J to byte address 0
    vecs = '{
      '{0,0,0}, '{0,0,0}, '{1,0,0}, '{0,0,0}, '{0,1,32'h33}, '{0,0,0},
      '{1,0,0}, '{1,0,0}, '{0,0,0}, '{1,1,32'h9D}, '{1,0,0}, '{0,0,0},
      '{0,0,0}, '{0,1,32'hF8}, '{0,0,0}, '{0,0,0}};

    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;

    // Reset: two cycles, then first instruction one cycle after release
    tick(); tick();
    check("rst_a1",    32'(imem_a1), 32'd0);
    check("rst_valid", 32'(if_valid), 32'd0);
    check("rst_if_pc", if_pc, 32'd0);
    check("rst_instr", if_instr, 32'd0);
    rst = 1'b0;
    tick();
    check("first_valid", 32'(if_valid), 32'd1);
    check("first_if_pc", if_pc, 32'h0);
    check("first_instr", if_instr, 32'hA000_0000);
    check("first_next",  if_instr_next, 32'hA000_0001);

    // Stall at pc=0x8 for three cycles
    tick();
    check("pre_stall_a1", 32'(imem_a1), 32'd2);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_a1",    32'(imem_a1), 32'd2);
      check("stall_if_pc", if_pc, 32'h4);
      check("stall_instr", if_instr, 32'hA000_0001);
    end
    stall = 1'b0;
    tick();
    check("release_if_pc", if_pc, 32'h8);

    // Redirect while stalled, misaligned target
    stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0026;
    tick();
    check("redir_a1",    32'(imem_a1), 32'd9);
    check("redir_valid", 32'(if_valid), 32'd0);
    stall = 1'b0; redirect_valid = 1'b0;
    tick();
    check("redir_if_pc", if_pc, 32'h24);
    check("redir_vld1",  32'(if_valid), 32'd1);
    check("redir_instr", if_instr, 32'hA000_0009);

    // Sequential wrap of the word address
    redirect_valid = 1'b1; redirect_pc = 32'h0000_00FC;
    tick();
    check("wrap_a1", 32'(imem_a1), 32'd63);
    check("wrap_a2", 32'(imem_a2), 32'd0);
    redirect_valid = 1'b0;
    tick();
    check("wrap_if_pc", if_pc, 32'hFC);
    check("wrap_instr", if_instr, 32'hA000_003F);
    check("wrap_next",  if_instr_next, 32'hA000_0000);
    check("wrap_a1_0",  32'(imem_a1), 32'd0);
    tick();
    check("wrap_if_pc2", if_pc, 32'h100);

    // J at pc=0x10
    redirect_valid = 1'b1; redirect_pc = 32'h10;
    tick();
    check("j_a1", 32'(imem_a1), 32'd4);
    redirect_valid = 1'b0;
    tick();
    check("j_if_pc", if_pc, 32'h10);
    check("j_instr", if_instr, 32'h0800_0000);
`ifdef FETCH_PREDECODE_EN
    check("j_pred",  32'(if_predicted), 32'd1);
    check("j_a1_nx", 32'(imem_a1), 32'd0);
`else
    check("j_pred",  32'(if_predicted), 32'd0);
    check("j_a1_nx", 32'(imem_a1), 32'd5);
`endif

    // Mixed stall/redirect sequence, checked by the model
    foreach (vecs[i]) begin
      stall = vecs[i].st; redirect_valid = vecs[i].rv; redirect_pc = vecs[i].tgt;
      tick();
    end
    stall = 1'b0; redirect_valid = 1'b0;
    tick();

    // Reset mid-run beats redirect and stall
    rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h40; stall = 1'b1;
    tick();
    check("mrst_a1",    32'(imem_a1), 32'd0);
    check("mrst_valid", 32'(if_valid), 32'd0);
    check("mrst_if_pc", if_pc, 32'h0);
    rst = 1'b0; redirect_valid = 1'b0; stall = 1'b0;
    tick();
    check("mrst_vld1",  32'(if_valid), 32'd1);
    check("mrst_instr", if_instr, 32'hA000_0000);
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
